// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

  localparam int PC_W        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEFAULT_TRAP_PC  = 32'h8000_0180;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: jump > taken branch > pc+4, plus alignment flag.
// Zero latency; no flow control of its own.
module pc_next_mux
  import pc_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_i,
  input  logic            zero_i,
  input  logic [PC_W-1:0] branch_offset_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] next_pc_o,
  output logic            next_misaligned_o
);

  logic [PC_W-1:0] branch_target;

  // Offset is in words; bits shifted past bit 31 are intentionally dropped.
  assign pc_plus4_o    = pc_i + PC_W'(INSTR_BYTES);
  assign branch_target = pc_plus4_o + (branch_offset_i << 2);

  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jump_i) begin
      next_pc_o = jump_target_i;
    end else if (branch_i && zero_i) begin
      next_pc_o = branch_target;
    end
  end

  assign next_misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// PC register with BOOT/RUN/TRAP control; pc updates one cycle after redirect inputs.
// Holds PC and retire count whenever stall is high or imem_ready is low.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            branch,
  input  logic            zero,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            misaligned,
  output logic [PC_W-1:0] retire_count
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            misaligned_q, misaligned_d;
  logic [PC_W-1:0] retire_q, retire_d;

  logic [PC_W-1:0] next_pc;
  logic            next_misaligned;
  logic            advance;

  pc_next_mux u_next_mux (
    .pc_i              (pc_q),
    .branch_i          (branch),
    .zero_i            (zero),
    .branch_offset_i   (branch_offset),
    .jump_i            (jump),
    .jump_target_i     (jump_target),
    .pc_plus4_o        (pc_plus4),
    .next_pc_o         (next_pc),
    .next_misaligned_o (next_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    misaligned_d  = misaligned_q;
    retire_d      = retire_q;
    advance       = 1'b0;
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        advance = !stall && imem_ready;
        if (advance) begin
          // A misaligned selected target traps instead of retiring.
          if (next_misaligned) begin
            state_d       = TRAP;
            pc_d          = TRAP_PC;
            misaligned_d  = 1'b1;
            fetch_valid_d = 1'b0;
          end else begin
            pc_d     = next_pc;
            retire_d = retire_q + 1'b1;
          end
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      retire_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      misaligned_q  <= misaligned_d;
      retire_q      <= retire_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign misaligned   = misaligned_q;
  assign retire_count = retire_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and next-PC selection stage for the single-cycle processor. Each cycle it chooses among sequential (PC+4), branch-target and jump-target addresses. It holds the PC on stall or instruction-memory not-ready, and traps on misaligned targets. It sits directly downstream of the jump-target and branch-offset logic and upstream of instruction memory. It also supplies PC+4 back to the jump-target stage.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h8000_0180, PC value loaded when a misaligned next-PC is detected.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  single clock.
  - reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC this cycle (datapath hazard or halt).
- imem_ready  in  1  instruction memory has accepted/returned the fetch at pc.
- branch  in  1  current instruction is a conditional branch.
- zero  in  1  ALU zero flag; the branch is taken when branch & zero.
- branch_offset  in  32  sign-extended immediate, in words.
- jump  in  1  current instruction is a jump.
- jump_target  in  32  full byte-address jump target from the jump-target stage.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc + 4, combinational from pc.
- fetch_valid  out  1  pc is a valid fetch address (registered).
- misaligned  out  1  sticky trap flag (registered).
- retire_count  out  32  count of PC advances since reset (registered).

## Operation

- FSM states:
  - BOOT: entered on reset. fetch_valid=0; the PC is not advanced. Moves to RUN unconditionally on the next cycle.
  - RUN: fetch_valid=1. Define advance = !stall & imem_ready.
    - On advance, pc <= next_pc and retire_count increments.
    - Otherwise pc and retire_count are held.
  - TRAP: entered when advance=1 and next_pc[1:0] != 2'b00.
    - On entry: pc <= TRAP_PC, misaligned <= 1, fetch_valid <= 0, retire_count is not incremented.
    - TRAP is absorbing: all inputs are ignored until reset.
- next_pc priority:
  1. jump=1 gives jump_target.
  2. Otherwise, branch & zero gives branch_target = pc_plus4 + (branch_offset << 2).
  3. Otherwise, pc_plus4.
- Arithmetic: all additions are unsigned modulo 2^32. Wrap-around is silent (0xFFFF_FFFC + 4 = 0x0000_0000). The bits shifted out of branch_offset << 2 are discarded.
- The alignment check applies only to the selected next_pc. An unselected misaligned candidate is ignored.
- Stall together with jump/branch: the PC is held. Upstream keeps jump/branch/target stable while the instruction is unchanged, so the redirect takes effect on the first advancing cycle.
- retire_count wraps modulo 2^32.
- Reset values: pc=RESET_PC, fetch_valid=0, misaligned=0, retire_count=0, state=BOOT.
- Reset asserted in any state (including TRAP or mid-stall) restores all reset values on the next edge.

## Timing

- All state updates occur on the rising edge of clk.
- pc_plus4 follows pc with combinational delay only.
- next_pc is combinational from inputs and pc. It is registered when advance=1 in RUN: one-cycle latency from redirect inputs to the pc output.
- First fetch: the first cycle after reset deasserts is BOOT (fetch_valid=0), so fetch_valid=1 one cycle later with pc=RESET_PC. The first advance can occur in that cycle.
- In RUN, imem_ready and stall are sampled every cycle. There is no minimum stall length.
- Trap: misaligned and fetch_valid change on the same edge as pc <= TRAP_PC.

## Structure

- Shared package pc_pkg:
  - state enum {BOOT, RUN, TRAP};
  - PC_W=32;
  - INSTR_BYTES=4;
  - default RESET_PC/TRAP_PC constants.
- One sub-module: pc_next_mux, purely combinational. It computes pc_plus4 and branch_target, applies the priority select, and outputs next_pc and next_misaligned.
- The top level holds the FSM, the pc register, the flags and retire_count.

## Test plan

- Reset with RESET_PC=0x0040_0000:
  - pc=0x0040_0000 and fetch_valid=0 for one cycle, then fetch_valid=1.
  - After 3 cycles with imem_ready=1: pc=0x0040_000C, retire_count=3.
- Branch at pc=0x0040_0010 with branch_offset=0xFFFF_FFFE:
  - branch=1, zero=1 gives pc=0x0040_000C.
  - Repeat with zero=0 gives pc=0x0040_0014.
- jump=1 together with a taken branch, jump_target=0x0040_0100: pc=0x0040_0100 next cycle (jump wins).
- stall=1 for 2 cycles, then imem_ready=0 for 1 cycle, with jump=1 and target 0x0040_0200:
  - pc and retire_count held throughout.
  - First advancing cycle gives pc=0x0040_0200, retire_count +1.
- jump_target=0x0040_0102:
  - Enters TRAP: pc=0x8000_0180, misaligned=1, fetch_valid=0; pc is unchanged by further inputs.
  - Assert reset: all outputs return to their reset values and the FSM returns to BOOT.
- Jump to 0xFFFF_FFFC, then one plain advance: pc=0x0000_0000, no trap, retire_count incremented.
